// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential divider slice.
//   DIV_WIDTH   : default divisor/remainder width (dividend/quotient = 2x)
//   div_state_t : controller state encoding (IDLE, RUN, DONE)
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One restoring shift-compare-subtract step (purely combinational).
// Ports:
//   rem_in  [WIDTH:0]   partial remainder from the previous step
//   divisor [WIDTH-1:0] unsigned divisor
//   bit_in              next dividend bit (MSB first)
//   rem_out [WIDTH:0]   partial remainder after this step
//   q_bit               quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    // One guard bit above the shifted value so that a divide-by-zero run,
    // where the remainder never shrinks, keeps shifting dividend bits through.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] dsr_ext;

    always_comb begin
        shifted = {rem_in, bit_in};
        dsr_ext = (WIDTH+2)'(divisor);
        if (shifted >= dsr_ext) begin
            rem_out = (WIDTH+1)'(shifted - dsr_ext);
            q_bit   = 1'b1;
        end else begin
            rem_out = (WIDTH+1)'(shifted);
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Sequential restoring unsigned divider, one quotient bit per clock.
// Optional feature macro: DIV_ZERO_DETECT_EN (zero-divisor bypass + dz flag).
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request, sampled only while idle
//   dividend   [2*WIDTH-1:0] numerator, captured on acceptance
//   divisor    [WIDTH-1:0]   denominator, captured on acceptance
//   busy       high while dividing
//   done       one-cycle pulse, results valid
//   quotient   [2*WIDTH-1:0] registered quotient
//   remainder  [WIDTH-1:0]   registered remainder
//   dz         divide-by-zero flag (only with DIV_ZERO_DETECT_EN)
// -----------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] quotient,
    output logic [WIDTH-1:0]   remainder
`ifdef DIV_ZERO_DETECT_EN
    ,
    output logic               dz
`endif
);

    localparam int CW = $clog2(2*WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(2*WIDTH);

    div_state_t         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] dvd;    // dividend bits shift out MSB-first, quotient bits shift in
    logic [WIDTH-1:0]   dsr;
    logic [WIDTH:0]     prem;
    logic [WIDTH:0]     nrem;
    logic               qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (prem),
        .divisor (dsr),
        .bit_in  (dvd[2*WIDTH-1]),
        .rem_out (nrem),
        .q_bit   (qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            cnt       <= '0;
            dvd       <= '0;
            dsr       <= '0;
            prem      <= '0;
`ifdef DIV_ZERO_DETECT_EN
            dz        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd  <= dividend;
                        dsr  <= divisor;
                        prem <= '0;
`ifdef DIV_ZERO_DETECT_EN
                        if (divisor == '0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend[WIDTH-1:0];
                            dz        <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            cnt   <= CNT_LOAD;
                        end
`else
                        state <= RUN;
                        busy  <= 1'b1;
                        cnt   <= CNT_LOAD;
`endif
                    end
                end
                RUN: begin
                    prem <= nrem;
                    dvd  <= {dvd[2*WIDTH-2:0], qbit};
                    cnt  <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= {dvd[2*WIDTH-2:0], qbit};
                        remainder <= nrem[WIDTH-1:0];
`ifdef DIV_ZERO_DETECT_EN
                        dz        <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Scoreboard bench for seq_divider: stimulus pushes arithmetic expectations,
// a negedge monitor pops and compares on every done pulse.
// Honours DIV_ZERO_DETECT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    localparam int W = 5;

    typedef struct {
        logic [2*W-1:0] dvd;
        logic [W-1:0]   dsr;
        logic [2*W-1:0] q;
        logic [W-1:0]   r;
        bit             dz;
        int unsigned    acc;
        int unsigned    lat;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [2*W-1:0] quotient;
    logic [W-1:0]   remainder;
`ifdef DIV_ZERO_DETECT_EN
    logic           dz;
`endif

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIV_ZERO_DETECT_EN
        ,
        .dz        (dz)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [2*W-1:0] last_q = '0;
    logic [W-1:0]   last_r = '0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division; zero divisor yields all-ones
    // quotient and the dividend's low bits as remainder.
    function automatic exp_t model(input logic [2*W-1:0] a, input logic [W-1:0] b,
                                   input int unsigned acc);
        exp_t e;
        e.dvd = a;
        e.dsr = b;
        e.acc = acc;
        e.dz  = 1'b0;
        e.lat = 2*W + 1;
        if (b == '0) begin
            e.q = '1;
            e.r = a[W-1:0];
`ifdef DIV_ZERO_DETECT_EN
            e.dz  = 1'b1;
            e.lat = 1;
`endif
        end else begin
            e.q = a / (2*W)'(b);
            e.r = W'(a % (2*W)'(b));
        end
        return e;
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            last_q = '0;
            last_r = '0;
        end else begin
            if (busy && done) chk("busy_done_overlap", 1, 0);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("quotient", 32'(quotient), 32'(e.q));
                    chk("remainder", 32'(remainder), 32'(e.r));
                    chk("latency", cyc - e.acc + 1, e.lat);
`ifdef DIV_ZERO_DETECT_EN
                    chk("dz", 32'(dz), 32'(e.dz));
`endif
                    if (e.dsr != '0) begin
                        chk("invariant", 32'(quotient) * 32'(e.dsr) + 32'(remainder), 32'(e.dvd));
                        chk("rem_lt_div", 32'(remainder < e.dsr), 1);
                    end
                    last_q = quotient;
                    last_r = remainder;
                end
            end else if (busy) begin
                chk("hold_quotient", 32'(quotient), 32'(last_q));
                chk("hold_remainder", 32'(remainder), 32'(last_r));
            end
        end
    end

    // Waits (bounded) for an idle negedge, scrambling operands meanwhile.
    task automatic wait_idle();
        int unsigned n = 0;
        @(negedge clk);
        while ((busy || done) && n < 100) begin
            dividend = (2*W)'($urandom);
            divisor  = W'($urandom);
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 1, 0);
    endtask

    task automatic issue(input logic [2*W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        wait_idle();
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e = model(a, b, cyc + 1);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), (e.lat > 1) ? 1 : 0);
        dividend = (2*W)'($urandom);
        divisor  = W'($urandom);
    endtask

    // start held high; a new accept must occur exactly every 12 cycles and
    // only the operands present on those edges count.
    task automatic hold_run(input int unsigned n);
        wait_idle();
        start = 1'b1;
        for (int unsigned k = 0; k < n; k++) begin
            logic [2*W-1:0] a;
            logic [W-1:0]   b;
            a = (2*W)'($urandom);
            b = W'($urandom_range(31, 1));
            dividend = a;
            divisor  = b;
            sb.push_back(model(a, b, cyc + 1));
            for (int unsigned j = 0; j < 11; j++) begin
                @(negedge clk);
                dividend = (2*W)'($urandom);
                divisor  = W'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int unsigned n;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_quotient", 32'(quotient), 0);
        chk("rst_remainder", 32'(remainder), 0);
`ifdef DIV_ZERO_DETECT_EN
        chk("rst_dz", 32'(dz), 0);
`endif
        rst_n = 1'b1;

        issue(10'd100, 5'd7);
        issue(10'd1023, 5'd31);
        issue(10'd1023, 5'd1);
        issue(10'd5, 5'd0);
        issue(10'd0, 5'd31);
        issue(10'd1023, 5'd0);
        issue(10'd30, 5'd31);
        issue(10'd31, 5'd31);

        hold_run(4);

        // Abort mid-division, then confirm a clean restart.
        wait_idle();
        dividend = 10'd100;
        divisor  = 5'd7;
        start    = 1'b1;
        sb.push_back(model(10'd100, 5'd7, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_quotient", 32'(quotient), 0);
        chk("abort_remainder", 32'(remainder), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        issue(10'd100, 5'd7);

        for (int unsigned i = 0; i < 300; i++) begin
            logic [W-1:0] b;
            b = ($urandom_range(15, 0) == 0) ? W'(0) : W'($urandom_range(31, 1));
            issue((2*W)'($urandom), b);
        end

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
